ex_muldiv_unit: RTL and testbench

Iterative unsigned multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (data_read1, data_read2, destination register). It performs one shift-add (MUL) or restore-subtract (DIV) step per clock over WIDTH cycles. While busy it raises stall so that the PC, IF/ID and ID/EX registers hold their contents. It returns a WIDTH-bit result plus its destination register to the EX/MEM write-back path.

---
 rtl/ex_muldiv_unit_pkg.sv | 21 ++
 rtl/ex_muldiv_unit_datapath.sv | 84 ++++++++
 rtl/ex_muldiv_unit.sv | 108 ++++++++++
 tb/tb_ex_muldiv_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit.
// The decoder that produces the op field imports the same constants.
package ex_muldiv_unit_pkg;

   typedef logic [1:0] muldiv_op_t;
   typedef logic [1:0] muldiv_state_t;

   localparam muldiv_op_t OP_MUL   = 2'b00;
   localparam muldiv_op_t OP_MULHU = 2'b01;
   localparam muldiv_op_t OP_DIVU  = 2'b10;
   localparam muldiv_op_t OP_REMU  = 2'b11;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_BUSY = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   function automatic logic op_is_div(input muldiv_op_t op);
      return op[1];
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_datapath.sv
// Shift-add multiply / restoring divide datapath: one step per enabled edge.
// result_o is the op-selected value *after* the current step, so the control
// can capture it on the same edge that performs the final step.
module muldiv_datapath
   import ex_muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  muldiv_op_t       load_op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             step_i,
   input  muldiv_op_t       op_q_i,
   output logic [WIDTH-1:0] result_o
);

   logic [2*WIDTH-1:0] prod_q, prod_d, mul_next;
   logic [WIDTH:0]     rem_q, rem_d, rem_next, rem_sh, mul_sum;
   logic [WIDTH-1:0]   quo_q, quo_d, quo_next, quo_sh, opb_q, opb_d;
   logic [WIDTH+1:0]   trial;

   always_comb begin
      // Carry out of the upper-half add becomes the new top bit after the shift.
      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
      mul_next = {mul_sum, prod_q[WIDTH-1:1]};

      rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      quo_sh = {quo_q[WIDTH-2:0], 1'b0};
      trial  = {1'b0, rem_sh} - {2'b00, opb_q};
      if (!trial[WIDTH+1]) begin
         rem_next = trial[WIDTH:0];
         quo_next = quo_sh | WIDTH'(1);
      end else begin
         rem_next = rem_sh;
         quo_next = quo_sh;
      end

      prod_d = prod_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      opb_d  = opb_q;
      if (load_i) begin
         opb_d = b_i;
         if (op_is_div(load_op_i)) begin
            rem_d = '0;
            quo_d = a_i;
         end else begin
            prod_d = {{WIDTH{1'b0}}, a_i};
         end
      end else if (step_i) begin
         if (op_is_div(op_q_i)) begin
            rem_d = rem_next;
            quo_d = quo_next;
         end else begin
            prod_d = mul_next;
         end
      end

      case (op_q_i)
         OP_MUL:   result_o = mul_next[WIDTH-1:0];
         OP_MULHU: result_o = mul_next[2*WIDTH-1:WIDTH];
         OP_DIVU:  result_o = quo_next;
         default:  result_o = rem_next[WIDTH-1:0];
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prod_q <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         opb_q  <= '0;
      end else begin
         prod_q <= prod_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         opb_q  <= opb_d;
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative unsigned mul/div: FSM, step counter, stall and flush control.
// Handshake: start_i is a level from ID/EX; the op is accepted on the first IDLE edge with start_i && !flush_i.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   input  logic [4:0]       dest_in_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic [WIDTH-1:0] result_o,
   output logic             result_valid_o,
   output logic [4:0]       result_dest_o,
   output logic [1:0]       dbg_state_o
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   muldiv_op_t       op_q, op_d;
   logic [4:0]       dest_q, dest_d, result_dest_q, result_dest_d;
   logic [WIDTH-1:0] result_q, result_d, dp_result;
   logic             result_valid_q, result_valid_d;
   logic             accept, step;

   assign accept = (state_q == S_IDLE) && start_i && !flush_i;
   assign step   = (state_q == S_BUSY) && !flush_i;

   muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (accept),
      .load_op_i (op_i),
      .a_i       (operand_a_i),
      .b_i       (operand_b_i),
      .step_i    (step),
      .op_q_i    (op_q),
      .result_o  (dp_result)
   );

   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      op_d           = op_q;
      dest_d         = dest_q;
      result_d       = result_q;
      result_dest_d  = result_dest_q;
      result_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_BUSY;
               count_d = '0;
               op_d    = op_i;
               dest_d  = dest_in_i;
            end
         end
         S_BUSY: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               count_d = count_q + CNT_W'(1);
               if (count_q == CNT_W'(WIDTH - 1)) begin
                  state_d        = S_DONE;
                  result_d       = dp_result;
                  result_dest_d  = dest_q;
                  result_valid_d = 1'b1;
               end
            end
         end
         // start_i seen here still belongs to the instruction just finished.
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= S_IDLE;
         count_q        <= '0;
         op_q           <= OP_MUL;
         dest_q         <= '0;
         result_q       <= '0;
         result_dest_q  <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         op_q           <= op_d;
         dest_q         <= dest_d;
         result_q       <= result_d;
         result_dest_q  <= result_dest_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign stall_o        = !rst_i && (accept || (state_q == S_BUSY));
   assign result_o       = result_q;
   assign result_valid_o = result_valid_q;
   assign result_dest_o  = result_dest_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: scoreboard of expected results,
// one task per scenario, inputs driven and outputs sampled around the falling edge.
module tb_ex_muldiv_unit;
   import ex_muldiv_unit_pkg::*;

   localparam int W = 32;
   localparam int LAT = 33;

   logic         clk = 1'b0;
   logic         rst, start, flush;
   logic [1:0]   op;
   logic [W-1:0] a, b;
   logic [4:0]   dest;
   logic         stall, rv;
   logic [W-1:0] result;
   logic [4:0]   result_dest;
   logic [1:0]   state;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [W-1:0] exp_q[$];
   logic [4:0]   exp_dest_q[$];
   logic [W-1:0] last_result;
   logic [4:0]   last_dest;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .op_i           (op),
      .operand_a_i    (a),
      .operand_b_i    (b),
      .dest_in_i      (dest),
      .flush_i        (flush),
      .stall_o        (stall),
      .result_o       (result),
      .result_valid_o (rv),
      .result_dest_o  (result_dest),
      .dbg_state_o    (state)
   );

   function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      case (o)
         OP_MUL:   return p[W-1:0];
         OP_MULHU: return p[2*W-1:W];
         OP_DIVU:  return (y == 0) ? {W{1'b1}} : x / y;
         default:  return (y == 0) ? x : x % y;
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; flush = 1'b0; op = OP_MUL; a = 7; b = 6; dest = 5'd9;
      repeat (2) @(negedge clk);
      #1;
      total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else pass_cnt++;
      total_cnt++; if (result !== '0) $display("FAIL reset_result: got %h expected 0", result); else pass_cnt++;
      total_cnt++; if (rv !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rv); else pass_cnt++;
      total_cnt++; if (result_dest !== 5'd0) $display("FAIL reset_dest: got %0d expected 0", result_dest); else pass_cnt++;
      total_cnt++; if (state !== S_IDLE) $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); else pass_cnt++;
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      last_result = '0;
      last_dest = '0;
   endtask

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [4:0] d, input string name);
      logic [W-1:0] e_res;
      logic [4:0]   e_dest;
      int stall_cnt, waited;
      bit seen;
      @(negedge clk);
      op = o; a = x; b = y; dest = d; start = 1'b1;
      exp_q.push_back(model(o, x, y));
      exp_dest_q.push_back(d);
      stall_cnt = 0; waited = 0; seen = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (rv) begin seen = 1; break; end
         if (stall) stall_cnt++;
         @(negedge clk);
         start = 1'b0;
         waited++;
      end
      start = 1'b0;
      total_cnt++; if (!seen) $display("FAIL %s_timeout: no result_valid within 100 cycles", name); else pass_cnt++;
      total_cnt++; if (waited != LAT) $display("FAIL %s_latency: got %0d expected %0d", name, waited, LAT); else pass_cnt++;
      total_cnt++; if (stall_cnt != LAT) $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stall_cnt, LAT); else pass_cnt++;
      total_cnt++; if (stall !== 1'b0) $display("FAIL %s_stall_done: got %b expected 0", name, stall); else pass_cnt++;
      e_res = exp_q.pop_front();
      e_dest = exp_dest_q.pop_front();
      total_cnt++; if (result !== e_res) $display("FAIL %s_result: got %h expected %h", name, result, e_res); else pass_cnt++;
      total_cnt++; if (result_dest !== e_dest) $display("FAIL %s_dest: got %0d expected %0d", name, result_dest, e_dest); else pass_cnt++;
      last_result = e_res;
      last_dest = e_dest;
      @(negedge clk);
      #1;
      total_cnt++; if (rv !== 1'b0) $display("FAIL %s_valid_one_cycle: got %b expected 0", name, rv); else pass_cnt++;
      total_cnt++; if (state !== S_IDLE) $display("FAIL %s_back_idle: got %0d expected %0d", name, state, S_IDLE); else pass_cnt++;
   endtask

   task automatic test_mul();
      run_op(OP_MUL, 32'd7, 32'd6, 5'd3, "mul_7x6");
      run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, "mul_max_lo");
      run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, "mul_max_hi");
   endtask

   task automatic test_div();
      run_op(OP_DIVU, 32'd100, 32'd7, 5'd6, "divu_100_7");
      run_op(OP_REMU, 32'd100, 32'd7, 5'd7, "remu_100_7");
      run_op(OP_DIVU, 32'h8000_0000, 32'd1, 5'd8, "divu_msb_1");
   endtask

   task automatic test_div_zero();
      run_op(OP_DIVU, 32'd1234, 32'd0, 5'd10, "divu_by0");
      run_op(OP_REMU, 32'd1234, 32'd0, 5'd11, "remu_by0");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         run_op(2'($urandom_range(0, 3)), $urandom, 32'($urandom_range(0, 32'hFFFF)),
                5'($urandom_range(0, 31)), "random");
      end
   endtask

   task automatic test_flush_and_reset();
      int extra;
      @(negedge clk);
      op = OP_MUL; a = 3; b = 5; dest = 5'd12; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      total_cnt++; if (state !== S_IDLE) $display("FAIL flush_state: got %0d expected %0d", state, S_IDLE); else pass_cnt++;
      total_cnt++; if (stall !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stall); else pass_cnt++;
      total_cnt++; if (rv !== 1'b0) $display("FAIL flush_valid: got %b expected 0", rv); else pass_cnt++;
      total_cnt++; if (result !== last_result) $display("FAIL flush_result_hold: got %h expected %h", result, last_result); else pass_cnt++;
      total_cnt++; if (result_dest !== last_dest) $display("FAIL flush_dest_hold: got %0d expected %0d", result_dest, last_dest); else pass_cnt++;
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (rv) extra++;
      end
      total_cnt++; if (extra != 0) $display("FAIL flush_no_strobe: got %0d strobes expected 0", extra); else pass_cnt++;

      @(negedge clk);
      op = OP_DIVU; a = 1000; b = 3; dest = 5'd13; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      total_cnt++; if (stall !== 1'b0) $display("FAIL midrst_stall: got %b expected 0", stall); else pass_cnt++;
      total_cnt++; if (result !== '0) $display("FAIL midrst_result: got %h expected 0", result); else pass_cnt++;
      total_cnt++; if (rv !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", rv); else pass_cnt++;
      total_cnt++; if (result_dest !== 5'd0) $display("FAIL midrst_dest: got %0d expected 0", result_dest); else pass_cnt++;
      total_cnt++; if (state !== S_IDLE) $display("FAIL midrst_state: got %0d expected %0d", state, S_IDLE); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      last_result = '0;
      last_dest = '0;
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (rv) extra++;
      end
      total_cnt++; if (extra != 0) $display("FAIL midrst_no_strobe: got %0d strobes expected 0", extra); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int n, rv_cnt, first_n, second_n, release_at;
      logic [W-1:0] e_res;
      logic [4:0]   e_dest;
      @(negedge clk);
      op = OP_MUL; a = 6; b = 7; dest = 5'd1; start = 1'b1;
      exp_q.push_back(model(OP_MUL, 6, 7));
      exp_dest_q.push_back(5'd1);
      n = 0; rv_cnt = 0; first_n = -1; second_n = -1; release_at = -1;
      while (n < 110) begin
         #1;
         if (rv) begin
            rv_cnt++;
            if (exp_q.size() == 0) begin
               total_cnt++;
               $display("FAIL b2b_extra_result: got result %h with nothing expected", result);
            end else begin
               e_res = exp_q.pop_front();
               e_dest = exp_dest_q.pop_front();
               total_cnt++; if (result !== e_res) $display("FAIL b2b_result: got %h expected %h", result, e_res); else pass_cnt++;
               total_cnt++; if (result_dest !== e_dest) $display("FAIL b2b_dest: got %0d expected %0d", result_dest, e_dest); else pass_cnt++;
            end
            if (rv_cnt == 1) begin
               first_n = n;
               release_at = n + 2;
               a = 9; b = 9; dest = 5'd2;
               exp_q.push_back(model(OP_MUL, 9, 9));
               exp_dest_q.push_back(5'd2);
            end else if (rv_cnt == 2) begin
               second_n = n;
            end
         end
         @(negedge clk);
         n++;
         if (n == release_at) start = 1'b0;
      end
      start = 1'b0;
      total_cnt++; if (rv_cnt != 2) $display("FAIL b2b_strobe_count: got %0d expected 2", rv_cnt); else pass_cnt++;
      total_cnt++; if (first_n != LAT) $display("FAIL b2b_first_latency: got %0d expected %0d", first_n, LAT); else pass_cnt++;
      total_cnt++; if (second_n - first_n != LAT + 1) $display("FAIL b2b_second_gap: got %0d expected %0d", second_n - first_n, LAT + 1); else pass_cnt++;
      total_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_sb_empty: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_random();
      test_flush_and_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
